// File: rtl/bit_reverse_reorder_ctrl_if.sv
// ---------------------------------------------------------------------------
// bit_reverse_reorder_ctrl_if
//
// Purpose : streaming handshake bundle for the bit-reverse reorder block.
//           It carries the natural-order input stream and the reordered
//           output stream.
//
// Signals :
//   in_data   [DATA_W]  natural-order input sample
//   in_valid            in_data is valid
//   in_ready            block can accept a sample
//   out_data  [DATA_W]  reordered output sample
//   out_valid           out_data is valid
//   out_ready           downstream accepts a sample
//   out_last            final sample of a frame
//
// Modports:
//   master  the producer/consumer side (drives inputs, takes outputs)
//   slave   the reorder block itself
// ---------------------------------------------------------------------------
interface bit_reverse_reorder_ctrl_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_last
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output out_last
  );

endinterface : bit_reverse_reorder_ctrl_if

// File: rtl/bit_reverse_reorder_ctrl.sv
// ---------------------------------------------------------------------------
// bit_reverse_reorder_ctrl
//
// Purpose : collects a frame of SAMPLES natural-order samples and replays it
//           in bit-reversed index order (output[j] = input[bitrev(j)]).
//           Samples are written to bit-reversed addresses while loading and
//           read back sequentially while draining, so the drain side is a
//           plain counter. One frame loads in SAMPLES cycles and drains in
//           SAMPLES cycles; the two phases do not overlap.
//
// Parameters:
//   SAMPLES  frame length (must equal 2**WIDTH)
//   WIDTH    index width
//   DATA_W   sample width
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous frame abort (frame_cnt is kept)
//   bus        handshake bundle (slave side), see bit_reverse_reorder_ctrl_if
//   busy       high when draining or when a partial frame is held
//   frame_cnt  completed output frames, wraps modulo 256
// ---------------------------------------------------------------------------
module bit_reverse_reorder_ctrl #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 3,
  parameter int DATA_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  bit_reverse_reorder_ctrl_if.slave   bus,
  output logic                        busy,
  output logic [7:0]                  frame_cnt
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(SAMPLES - 1);

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [WIDTH-1:0]  wr_cnt;
  logic [WIDTH-1:0]  rd_cnt;

  logic [DATA_W-1:0] storage [SAMPLES];

  logic              in_ready;
  logic              out_valid;
  logic              out_last;
  logic              in_xfer;
  logic              out_xfer;

  // Mirror the index bits: bit i moves to bit WIDTH-1-i.
  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[WIDTH-1-i] = idx[i];
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;

    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        // Last sample of the frame accepted: drain from the next cycle on.
        if (bus.in_valid && (wr_cnt == LAST_IDX)) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_cnt == LAST_IDX);
        if (bus.out_ready && out_last) begin
          state_next = LOAD;
        end
      end

      default: begin
        state_next = LOAD;
      end
    endcase
  end

  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = out_valid && bus.out_ready;

  // -------------------------------------------------------------------------
  // Write / read / frame counters
  // -------------------------------------------------------------------------
  // The WIDTH-bit counters wrap to zero naturally after SAMPLES-1 because
  // SAMPLES == 2**WIDTH. flush clears the position counters but keeps the
  // completed-frame count, and it wins over a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      frame_cnt <= '0;
    end else if (flush) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      if (in_xfer) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (out_xfer) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (out_last) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sample storage
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset; its contents only become visible
  // after a full frame has been written, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (!rst && !flush && in_xfer) begin
      storage[bitrev(wr_cnt)] <= bus.in_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // out_data is a direct register read; it is forced to zero outside DRAIN so
  // stale or never-written storage cannot leak onto the bus.
  assign bus.out_data  = out_valid ? storage[rd_cnt] : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.in_ready  = in_ready;

  assign busy = (state != LOAD) || (wr_cnt != '0);

endmodule : bit_reverse_reorder_ctrl

// File: tb/tb_bit_reverse_reorder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bit_reverse_reorder_ctrl
//
// Self-checking bench for bit_reverse_reorder_ctrl (SAMPLES=8, DATA_W=16).
// The reference model is a pair of queues: "partial" collects accepted
// samples of the frame being loaded; once it holds SAMPLES entries it is
// turned into "pending", the expected output order built with an
// arithmetic index mirror. Every expected handshake value follows from
// those queues alone.
// ---------------------------------------------------------------------------
module tb_bit_reverse_reorder_ctrl;

  localparam int SAMPLES = 8;
  localparam int WIDTH   = 3;
  localparam int DATA_W  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       busy;
  logic [7:0] frame_cnt;

  bit_reverse_reorder_ctrl_if #(.DATA_W(DATA_W)) bus ();

  bit_reverse_reorder_ctrl #(
    .SAMPLES (SAMPLES),
    .WIDTH   (WIDTH),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [DATA_W-1:0] partial [$];
  logic [DATA_W-1:0] pending [$];
  logic [7:0]        frames_done = 8'd0;

  // Index mirror computed arithmetically: peel low bits off j and push them
  // into r from the other end.
  function automatic int mirror(input int j);
    int r;
    int v;
    r = 0;
    v = j;
    for (int b = 0; b < WIDTH; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare DUT outputs against the model
  // mid-cycle, then advance the model by what the edge should do.
  task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                      input logic fl, input logic rs, input bit chk, output bit accepted);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    rst           = rs;
    #2;
    if (chk) begin
      check("in_ready",  32'(bus.in_ready),  32'(pending.size() == 0));
      check("out_valid", 32'(bus.out_valid), 32'(pending.size() != 0));
      check("out_last",  32'(bus.out_last),  32'(pending.size() == 1));
      check("busy",      32'(busy),          32'((pending.size() != 0) || (partial.size() != 0)));
      check("frame_cnt", 32'(frame_cnt),     32'(frames_done));
      if (pending.size() != 0) begin
        check("out_data", 32'(bus.out_data), 32'(pending[0]));
      end
    end
    accepted = 1'b0;
    @(posedge clk);
    if (rs) begin
      partial.delete();
      pending.delete();
      frames_done = 8'd0;
    end else if (fl) begin
      partial.delete();
      pending.delete();
    end else if (pending.size() != 0) begin
      if (ordy) begin
        void'(pending.pop_front());
        if (pending.size() == 0) frames_done++;
      end
    end else if (iv) begin
      accepted = 1'b1;
      partial.push_back(d);
      if (partial.size() == SAMPLES) begin
        for (int j = 0; j < SAMPLES; j++) pending.push_back(partial[mirror(j)]);
        partial.delete();
      end
    end
    #1;
  endtask

  // Load a full frame with out_ready low; data is base+k or random.
  task automatic load_frame(input int base, input bit rnd);
    bit acc;
    for (int k = 0; k < SAMPLES; k++) begin
      step(1'b1, rnd ? DATA_W'($urandom) : DATA_W'(base + k), 1'b0, 1'b0, 1'b0, 1'b1, acc);
    end
  endtask

  // Drain up to max_out transfers. stall=1 uses the 1,0,0 ready pattern.
  task automatic drain(input int max_out, input bit stall);
    bit acc;
    int outs;
    int cyc;
    logic ordy;
    outs = 0;
    cyc  = 0;
    while (pending.size() != 0 && outs < max_out && cyc < 64) begin
      ordy = stall ? ((cyc % 3) == 0) : 1'b1;
      step(1'b0, DATA_W'($urandom), ordy, 1'b0, 1'b0, 1'b1, acc);
      if (ordy) outs++;
      cyc++;
    end
  endtask

  initial begin
    bit          acc;
    logic [DATA_W-1:0] d;
    int          base_frames;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    rst           = 1'b1;

    // Reset, then check the reset state on the idle cycle after.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

    // Inputs 0..7, out_ready held high: 0,4,2,6,1,5,3,7.
    load_frame(0, 1'b0);
    drain(SAMPLES, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, acc);

    // Same frame, out_ready pattern 1,0,0,...: stalls hold out_data.
    load_frame(0, 1'b0);
    drain(SAMPLES, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

    // Flush after 5 inputs (with a same-cycle input that must be dropped),
    // then 10..17.
    for (int k = 0; k < 5; k++) step(1'b1, DATA_W'(100 + k), 1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, DATA_W'(16'hdead), 1'b0, 1'b1, 1'b0, 1'b1, acc);
    load_frame(10, 1'b0);
    drain(SAMPLES, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

    // Reset after 3 output transfers (reset wins over the transfer), then a
    // clean random frame.
    load_frame(0, 1'b1);
    drain(3, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    load_frame(0, 1'b1);
    drain(SAMPLES, 1'b0);

    // Three back-to-back frames, in_valid and out_ready held high.
    base_frames = int'(frames_done);
    d = DATA_W'($urandom);
    for (int cyc = 0; cyc < 3 * 2 * SAMPLES; cyc++) begin
      step(1'b1, d, 1'b1, 1'b0, 1'b0, 1'b1, acc);
      if (acc) d = DATA_W'($urandom);
    end
    check("b2b_frames", 32'(frame_cnt), 32'((base_frames + 3) % 256));

    // flush on the out_last transfer: back to LOAD, frame_cnt unchanged.
    load_frame(0, 1'b1);
    drain(SAMPLES - 1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

    // Random traffic with occasional flushes.
    for (int cyc = 0; cyc < 400; cyc++) begin
      step(1'($urandom), DATA_W'($urandom), 1'($urandom),
           ($urandom_range(0, 39) == 0), 1'b0, 1'b1, acc);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bit_reverse_reorder_ctrl
